// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  localparam int INSTR_W     = 32;
  localparam int PC_W        = 64;
  localparam int ROM_ADDR_W  = 32;
  localparam int ROM_IDX_W   = 8;
  localparam int ROM_IDX_LSB = 12;
  localparam logic [11:0] ROM_SEL = 12'hFFF;

  // Legacy encodings kept alongside the enum so older code can compare raw bits.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // ROM word index sits above a fixed all-ones select field so the ROM always decodes.
  function automatic logic [ROM_ADDR_W-1:0] rom_addr_of(input logic [ROM_IDX_W-1:0] idx);
    return {{(ROM_ADDR_W-ROM_IDX_LSB-ROM_IDX_W){1'b0}}, idx, ROM_SEL};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous fetch buffer with flush, head register output
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;

  // Head is read from storage; nothing reaches decode while the buffer is empty.
  assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update: flush and reset both return to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC sequencing, ROM addressing and fetch buffer control
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [31:0]        rom_addr,
  input  logic [63:0]        rom_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc
);

  fetch_state_e    state;
  logic [PC_W-1:0] pc;
  logic            buf_full;
  logic            buf_empty;
  logic            do_pop;
  logic            do_fetch;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic            unused_bits;

  // Upper ROM word and the redirect byte offset carry no information for fetch.
  assign unused_bits = ^{rom_data[63:32], redirect_pc[1:0]};

  assign rom_addr = rom_addr_of(pc[ROM_IDX_W+1:2]);

  // A redirect cancels both the pop and the fetch of its cycle.
  assign do_pop   = if_valid && if_ready && !redirect_valid;
  assign do_fetch = (state == RUN) && fetch_en && !redirect_valid && (!buf_full || do_pop);

  assign push_entry.pc    = pc;
  assign push_entry.instr = rom_data[INSTR_W-1:0];

  assign if_valid = !buf_empty;
  assign if_pc    = head_entry.pc;
  assign if_instr = head_entry.instr;

  // Run/idle control follows fetch_en; redirects do not change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (fetch_en)  state <= RUN;
        RUN:     if (!fetch_en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Program counter: redirect target wins, otherwise step one word per fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[PC_W-1:2], 2'b00};
    end else if (do_fetch) begin
      pc <= pc + 64'd4;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (do_fetch),
    .push_data (push_entry),
    .pop       (do_pop),
    .head_data (head_entry),
    .full      (buf_full),
    .empty     (buf_empty)
  );

endmodule
